// File: rtl/microsequencer_pkg.sv
// Shared control-unit definitions: state width, next-state modes, condition
// sources and the two fixed microstore addresses.
package microsequencer_pkg;
  localparam int STATE_W = 10;
  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [2:0] {
    N_INC   = 3'b000,
    N_JMP   = 3'b001,
    N_DEC   = 3'b010,
    N_BRC   = 3'b011,
    N_WAITC = 3'b100,
    N_JWAIT = 3'b101,
    N_FETCH = 3'b110,
    N_HOLD  = 3'b111
  } nmode_e;

  typedef enum logic [1:0] {
    SEL_MOC  = 2'b00,
    SEL_COND = 2'b01,
    SEL_Z    = 2'b10,
    SEL_ONE  = 2'b11
  } csel_e;

  localparam state_t FETCH_STATE = 10'd1;
  localparam state_t FAULT_STATE = 10'h3FF;
endpackage

// File: rtl/microsequencer_if.sv
// Microword, status and state bundle between the control store and the sequencer.
interface microsequencer_if;
  import microsequencer_pkg::*;
  logic [2:0] N;
  logic       inv;
  logic [1:0] select;
  state_t     cr;
  state_t     decoded_state;
  logic       moc;
  logic       cond;
  logic       z_flag;
  logic       stall;
  state_t     current_state;
  logic       fault;

  modport master (
    output N, inv, select, cr, decoded_state, moc, cond, z_flag, stall,
    input  current_state, fault
  );
  modport slave (
    input  N, inv, select, cr, decoded_state, moc, cond, z_flag, stall,
    output current_state, fault
  );
endinterface

// File: rtl/microsequencer_condition_select.sv
// Combinational branch-condition picker with optional inversion.
module condition_select
  import microsequencer_pkg::*;
(
  input  logic [1:0] select_i,
  input  logic       inv_i,
  input  logic       moc_i,
  input  logic       cond_i,
  input  logic       z_flag_i,
  output logic       c_o
);
  logic src;

  always_comb begin
    src = 1'b1;
    case (csel_e'(select_i))
      SEL_MOC:  src = moc_i;
      SEL_COND: src = cond_i;
      SEL_Z:    src = z_flag_i;
      SEL_ONE:  src = 1'b1;
      default:  src = 1'b1;
    endcase
  end

  assign c_o = src ^ inv_i;
endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: picks the next microstore address each clock and
// flags illegal decodes with a sticky fault.
module microsequencer
  import microsequencer_pkg::*;
(
  input  logic            clk,
  input  logic            clr_n,
  microsequencer_if.slave bus
);
  state_t state_q, state_d, inc;
  logic   fault_q, fault_d;
  logic   c;

  condition_select u_cond (
    .select_i (bus.select),
    .inv_i    (bus.inv),
    .moc_i    (bus.moc),
    .cond_i   (bus.cond),
    .z_flag_i (bus.z_flag),
    .c_o      (c)
  );

  // Natural 10-bit overflow gives the 3FF -> 0 wrap.
  assign inc = state_q + 10'd1;

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    if (!bus.stall) begin
      case (nmode_e'(bus.N))
        N_INC:   state_d = inc;
        N_JMP:   state_d = bus.cr;
        N_DEC: begin
          if (bus.decoded_state == '0) begin
            state_d = FAULT_STATE;
            fault_d = 1'b1;
          end else begin
            state_d = bus.decoded_state;
          end
        end
        N_BRC:   state_d = c ? bus.cr : inc;
        N_WAITC: state_d = c ? inc : state_q;
        N_JWAIT: state_d = c ? bus.cr : state_q;
        N_FETCH: state_d = FETCH_STATE;
        N_HOLD:  state_d = state_q;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign bus.current_state = state_q;
  assign bus.fault         = fault_q;
endmodule

// File: tb/tb_microsequencer.sv
// Directed scenarios plus a randomized run against an arithmetic reference model.
module tb_microsequencer;
  logic clk = 1'b0;
  logic clr_n;
  int   checks = 0;
  int   errors = 0;
  int   ms;   // model state
  bit   mf;   // model fault

  microsequencer_if vif ();

  microsequencer dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (vif.slave)
  );

  always #5 clk = ~clk;

  function automatic void model_edge();
    bit src, c;
    if (!clr_n || vif.stall) return;
    case (vif.select)
      2'd0: src = vif.moc;
      2'd1: src = vif.cond;
      2'd2: src = vif.z_flag;
      default: src = 1'b1;
    endcase
    c = src ^ vif.inv;
    case (vif.N)
      3'd0: ms = (ms + 1) % 1024;
      3'd1: ms = int'(vif.cr);
      3'd2: if (vif.decoded_state == 0) begin ms = 1023; mf = 1'b1; end
            else ms = int'(vif.decoded_state);
      3'd3: ms = c ? int'(vif.cr) : (ms + 1) % 1024;
      3'd4: if (c) ms = (ms + 1) % 1024;
      3'd5: if (c) ms = int'(vif.cr);
      3'd6: ms = 1;
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic [2:0] n, input logic iv, input logic [1:0] sel,
                        input logic [9:0] cr, input logic [9:0] dec, input logic moc,
                        input logic st);
    @(negedge clk);
    vif.N = n; vif.inv = iv; vif.select = sel; vif.cr = cr;
    vif.decoded_state = dec; vif.moc = moc; vif.stall = st;
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    #1;
    checks++;
    if (vif.current_state !== 10'd0 || vif.fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got state=%h fault=%b, want 000/0", vif.current_state, vif.fault);
    end
    set_in(3'b110, 0, 0, 0, 10'd5, 0, 0);
    clr_n = 1'b1;
    tick();
    checks++;
    if (vif.current_state !== 10'd1) begin
      errors++;
      $display("FAIL reset_fetch: got %h want 001", vif.current_state);
    end
    // enter a wait that would never complete, then reset in the middle of it
    set_in(3'b100, 0, 0, 0, 10'd5, 0, 0);
    tick();
    exp = ms[9:0];
    checks++;
    if (vif.current_state !== exp) begin
      errors++;
      $display("FAIL reset_wait_hold: got %h want %h", vif.current_state, exp);
    end
    @(negedge clk);
    #2 clr_n = 1'b0;
    ms = 0; mf = 0;
    #1;
    checks++;
    if (vif.current_state !== 10'd0 || vif.fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got state=%h fault=%b, want 000/0", vif.current_state, vif.fault);
    end
    vif.N = 3'b110;
    #1 clr_n = 1'b1;
    tick();
    checks++;
    if (vif.current_state !== 10'd1) begin
      errors++;
      $display("FAIL reset_release_fetch: got %h want 001", vif.current_state);
    end
  endtask

  task automatic test_decode();
    set_in(3'b010, 0, 0, 0, 10'h02A, 0, 0);
    tick();
    checks++;
    if (vif.current_state !== 10'd42 || vif.fault !== 1'b0) begin
      errors++;
      $display("FAIL decode_ok: got state=%h fault=%b, want 02a/0", vif.current_state, vif.fault);
    end
    set_in(3'b010, 0, 0, 0, 10'h000, 0, 0);
    tick();
    checks++;
    if (vif.current_state !== 10'h3FF || vif.fault !== 1'b1) begin
      errors++;
      $display("FAIL decode_illegal: got state=%h fault=%b, want 3ff/1", vif.current_state, vif.fault);
    end
    set_in(3'b110, 0, 0, 0, 10'h000, 0, 0);
    tick();
    checks++;
    if (vif.current_state !== 10'd1 || vif.fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_refetch: got state=%h fault=%b, want 001/1", vif.current_state, vif.fault);
    end
    for (int i = 0; i < 5; i++) begin
      set_in(3'b000, 0, 0, 0, 10'h001, 0, 0);
      tick();
      checks++;
      if (vif.fault !== 1'b1 || vif.current_state !== 10'(i + 2)) begin
        errors++;
        $display("FAIL fault_sticky[%0d]: got state=%h fault=%b, want %h/1", i,
                 vif.current_state, vif.fault, 10'(i + 2));
      end
    end
  endtask

  task automatic test_wait();
    logic [9:0] held;
    set_in(3'b001, 0, 0, 10'h123, 10'h001, 0, 0);
    tick();
    held = vif.current_state;
    for (int i = 0; i < 3; i++) begin
      set_in(3'b100, 0, 2'b00, 0, 10'h001, 0, 0);
      tick();
      checks++;
      if (vif.current_state !== 10'h123) begin
        errors++;
        $display("FAIL wait_hold[%0d]: got %h want 123", i, vif.current_state);
      end
    end
    set_in(3'b100, 0, 2'b00, 0, 10'h001, 1, 0);
    tick();
    checks++;
    if (vif.current_state !== 10'h124) begin
      errors++;
      $display("FAIL wait_release: got %h want 124 (was %h)", vif.current_state, held);
    end
  endtask

  task automatic test_branch();
    set_in(3'b001, 0, 0, 10'd7, 10'h001, 0, 0);
    tick();
    vif.z_flag = 1'b1;
    set_in(3'b011, 1, 2'b10, 10'h050, 10'h001, 0, 0);
    tick();
    checks++;
    if (vif.current_state !== 10'd8) begin
      errors++;
      $display("FAIL branch_inv1: got %h want 008", vif.current_state);
    end
    set_in(3'b001, 0, 0, 10'd7, 10'h001, 0, 0);
    tick();
    set_in(3'b011, 0, 2'b10, 10'h050, 10'h001, 0, 0);
    tick();
    checks++;
    if (vif.current_state !== 10'h050) begin
      errors++;
      $display("FAIL branch_inv0: got %h want 050", vif.current_state);
    end
  endtask

  task automatic test_stall_wrap();
    set_in(3'b001, 0, 0, 10'h3FF, 10'h001, 0, 0);
    tick();
    set_in(3'b001, 0, 0, 10'h155, 10'h001, 0, 1);
    tick();
    checks++;
    if (vif.current_state !== 10'h3FF) begin
      errors++;
      $display("FAIL stall_hold: got %h want 3ff", vif.current_state);
    end
    set_in(3'b000, 0, 0, 0, 10'h001, 0, 0);
    tick();
    checks++;
    if (vif.current_state !== 10'h000) begin
      errors++;
      $display("FAIL wrap: got %h want 000", vif.current_state);
    end
  endtask

  task automatic test_random();
    logic [9:0] exp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      vif.N      = 3'($urandom_range(0, 7));
      vif.inv    = 1'($urandom);
      vif.select = 2'($urandom);
      vif.cr     = 10'($urandom);
      vif.decoded_state = ($urandom_range(0, 5) == 0) ? 10'h000 : 10'($urandom);
      vif.moc    = 1'($urandom);
      vif.cond   = 1'($urandom);
      vif.z_flag = 1'($urandom);
      vif.stall  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) begin
        #2 clr_n = 1'b0;
        ms = 0; mf = 0;
        #1 clr_n = 1'b1;
      end
      tick();
      exp = ms[9:0];
      checks++;
      if (vif.current_state !== exp || vif.fault !== mf) begin
        errors++;
        $display("FAIL random[%0d]: got state=%h fault=%b, want %h/%b", i,
                 vif.current_state, vif.fault, exp, mf);
      end
    end
  endtask

  initial begin
    clr_n = 1'b0;
    ms = 0; mf = 0;
    vif.N = 3'b110; vif.inv = 0; vif.select = 0; vif.cr = 0;
    vif.decoded_state = 10'd1; vif.moc = 0; vif.cond = 0; vif.z_flag = 0; vif.stall = 0;
    test_reset();
    test_decode();
    test_wait();
    test_branch();
    test_stall_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
